// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch responder.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } imem_state_e;

   localparam logic [31:0] IMEM_NOP         = 32'h0000_0000;
   localparam int unsigned IMEM_ADDR_W_DEF  = 8;
   localparam int unsigned IMEM_LATENCY_DEF = 2;

   function automatic logic imem_in_range(input logic [31:0] addr, input int unsigned addr_w);
      return (addr >> addr_w) == '0;
   endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous write port, two combinational read ports.
module imem_array
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] rd_a_addr_i,
   output logic [31:0]       rd_a_data_o,
   input  logic [ADDR_W-1:0] rd_b_addr_i,
   output logic [31:0]       rd_b_data_o
);

   logic [31:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rd_a_data_o = mem_q[rd_a_addr_i];
   assign rd_b_data_o = mem_q[rd_b_addr_i];

endmodule

// File: rtl/imem_fetch_responder.sv
// Fixed-latency instruction fetch responder with PC stall and load port.
// Optional next-word prefetch buffer enabled by IMEM_PREFETCH_EN.
module imem_fetch_responder
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W  = IMEM_ADDR_W_DEF,
   parameter int unsigned LATENCY = IMEM_LATENCY_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_instr,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        fault
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   imem_state_e state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_instr_q;
   logic        fault_q;

   logic [31:0] fetch_raddr_w;
   logic [31:0] fetch_rdata_w;
   logic [31:0] fetch_data_w;
   logic        fetch_oor_w;
   logic        acc_direct_w;
   logic [31:0] acc_data_w;
   logic [3:0]  acc_cnt_w;
   logic [31:0] pf_raddr_w;
   logic [31:0] pf_rdata_w;

   // In IDLE the accept edge itself may deliver (LATENCY=1), so read the live request.
   assign fetch_raddr_w = (state_q == IDLE) ? req_addr : addr_q;
   assign fetch_oor_w   = !imem_in_range(fetch_raddr_w, ADDR_W);
   assign fetch_data_w  = fetch_oor_w ? IMEM_NOP : fetch_rdata_w;

   imem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i       (clock),
      .we_i        (load_en && imem_in_range(load_addr, ADDR_W)),
      .waddr_i     (load_addr[ADDR_W-1:0]),
      .wdata_i     (load_data),
      .rd_a_addr_i (fetch_raddr_w[ADDR_W-1:0]),
      .rd_a_data_o (fetch_rdata_w),
      .rd_b_addr_i (pf_raddr_w[ADDR_W-1:0]),
      .rd_b_data_o (pf_rdata_w)
   );

`ifdef IMEM_PREFETCH_EN
   logic [31:0] pf_addr_q;
   logic [31:0] pf_data_q;
   logic [3:0]  pf_cnt_q;
   logic        pf_pend_q;
   logic        pf_done_q;
   logic        buf_hit_w;

   assign pf_raddr_w = pf_addr_q;
   // A load on the accept edge would invalidate the buffer, so it never hits then.
   assign buf_hit_w  = (req_addr == pf_addr_q) && (pf_pend_q || pf_done_q) && !load_en;
   assign acc_direct_w = (LATENCY == 1) || (buf_hit_w && (pf_done_q || pf_cnt_q == '0));
   assign acc_data_w   = (buf_hit_w && pf_done_q) ? pf_data_q : fetch_data_w;
   assign acc_cnt_w    = buf_hit_w ? pf_cnt_q : LAT_M1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pf_addr_q <= '0;
         pf_data_q <= '0;
         pf_cnt_q  <= '0;
         pf_pend_q <= 1'b0;
         pf_done_q <= 1'b0;
      end else begin
         if (pf_pend_q) begin
            if (pf_cnt_q == '0) begin
               pf_data_q <= imem_in_range(pf_addr_q, ADDR_W) ? pf_rdata_w : IMEM_NOP;
               pf_done_q <= 1'b1;
               pf_pend_q <= 1'b0;
            end else begin
               pf_cnt_q <= pf_cnt_q - 4'd1;
            end
         end
         if (state_q == IDLE && req_valid) begin
            pf_pend_q <= 1'b0;
            pf_done_q <= 1'b0;
         end else if (state_q == RESP) begin
            pf_addr_q <= addr_q + 32'd1;
            pf_cnt_q  <= LAT_M1;
            pf_pend_q <= 1'b1;
            pf_done_q <= 1'b0;
         end
         if (load_en) begin
            pf_pend_q <= 1'b0;
            pf_done_q <= 1'b0;
         end
      end
   end
`else
   logic [31:0] unused_pf_rdata;

   assign pf_raddr_w      = '0;
   assign unused_pf_rdata = pf_rdata_w;
   assign acc_direct_w    = (LATENCY == 1);
   assign acc_data_w      = fetch_data_w;
   assign acc_cnt_w       = LAT_M1;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  if (acc_direct_w) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_instr_q <= acc_data_w;
                     if (fetch_oor_w) fault_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= acc_cnt_w;
                  end
               end
            end
            // Counter reaching 0 on this edge marks the RESP-entry edge.
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_instr_q <= fetch_data_w;
                  if (fetch_oor_w) fault_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign stall     = (state_q == IDLE && req_valid) || (state_q == WAIT);
   assign rsp_valid = rsp_valid_q;
   assign rsp_instr = rsp_instr_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder (default ADDR_W=8, LATENCY=2).
module tb_imem_fetch_responder;

   localparam int unsigned AW  = 8;
   localparam int unsigned LAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_instr;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_data = '0;
   logic        fault;

   imem_fetch_responder #(
      .ADDR_W  (AW),
      .LATENCY (LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .stall     (stall),
      .rsp_valid (rsp_valid),
      .rsp_instr (rsp_instr),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .fault     (fault)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] instr;
      int          due;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] model_mem [2**AW];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Response monitor: pops the oldest expected response and checks data and arrival cycle.
   always @(negedge clock) begin
      if (!reset && rsp_valid) begin
         if (sb.size() == 0) begin
            check_val("spurious_rsp", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_val("rsp_instr", rsp_instr, mon_e.instr);
            check_val("rsp_cycle", cyc, mon_e.due);
            check_val("stall_in_rsp", {31'd0, stall}, 32'd0);
         end
      end
   end

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clock);
      load_en = 1'b0;
      if ((a >> AW) == 0) model_mem[a[AW-1:0]] = d;
   endtask

   // ld_when: 0 none, 1 load in request cycle, 2 load in following cycle.
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input int lat,
                           input int ld_when, input logic [31:0] ld_a, input logic [31:0] ld_d);
      int nst;
      int i;
      @(negedge clock);
      req_valid = 1'b1; req_addr = a;
      if (ld_when == 1) begin load_en = 1'b1; load_addr = ld_a; load_data = ld_d; end
      sb.push_back('{instr: exp, due: cyc + lat});
      #1 nst = stall ? 1 : 0;
      @(posedge clock);
      #1 req_valid = 1'b0; load_en = 1'b0;
      i = 0;
      while (sb.size() != 0 && i < 40) begin
         @(negedge clock);
         if (i == 0 && ld_when == 2) begin load_en = 1'b1; load_addr = ld_a; load_data = ld_d; end
         else load_en = 1'b0;
         #1 if (stall) nst++;
         i++;
      end
      load_en = 1'b0;
      if (sb.size() != 0) begin
         check_val("rsp_timeout", 32'd1, 32'd0);
         sb.delete();
      end
      check_val("stall_cycles", nst, lat);
   endtask

   initial begin
      int pc;
      int last_pc;
      int k;
      logic st;

      repeat (3) @(negedge clock);
      check_val("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("reset_rsp_instr", rsp_instr, 32'd0);
      check_val("reset_fault", {31'd0, fault}, 32'd0);
      check_val("reset_stall", {31'd0, stall}, 32'd0);
      reset = 1'b0;

      for (int w = 0; w < 16; w++) load_word(w, 32'h1000_0000 + 32'(w) * 32'h0101);
      load_word(3, 32'h2008_0005);

      do_fetch(3, 32'h2008_0005, LAT, 0, 0, 0);

      // PC model: advances its address on every edge where stall is low.
      pc = 0; last_pc = -1; k = 0;
      while (!(pc == 3 && sb.size() == 0) && k < 40) begin
         @(negedge clock);
         if (pc < 3) begin
            if (pc != last_pc) begin
               sb.push_back('{instr: model_mem[pc], due: cyc + LAT});
               last_pc = pc;
            end
            req_valid = 1'b1; req_addr = pc;
         end else begin
            req_valid = 1'b0;
         end
         #1 st = stall;
         if (req_valid && !st) pc++;
         k++;
      end
      req_valid = 1'b0;
      check_val("pc_final", pc, 3);
      if (sb.size() != 0) begin check_val("pc_rsp_timeout", 32'd1, 32'd0); sb.delete(); end

      load_word(32'h0000_0100, 32'hDEAD_BEEF);
      check_val("oor_load_fault", {31'd0, fault}, 32'd0);
      do_fetch(0, model_mem[0], LAT, 0, 0, 0);
      do_fetch(32'h0000_0100, 32'h0, LAT, 0, 0, 0);
      check_val("oor_fetch_fault", {31'd0, fault}, 32'd1);
      do_fetch(1, model_mem[1], LAT, 0, 0, 0);
      check_val("fault_sticky", {31'd0, fault}, 32'd1);

      @(negedge clock);
      req_valid = 1'b1; req_addr = 2;
      @(posedge clock);
      #1 req_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_val("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("rst_wait_rsp_instr", rsp_instr, 32'd0);
      check_val("rst_wait_stall", {31'd0, stall}, 32'd0);
      check_val("rst_wait_fault", {31'd0, fault}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      do_fetch(2, model_mem[2], LAT, 0, 0, 0);

      do_fetch(5, 32'hAAAA_0000, LAT, 1, 5, 32'hAAAA_0000);
      model_mem[5] = 32'hAAAA_0000;
      do_fetch(5, 32'hAAAA_0000, LAT, 2, 5, 32'h5555_1111);
      model_mem[5] = 32'h5555_1111;
      do_fetch(5, 32'h5555_1111, LAT, 0, 0, 0);

`ifdef IMEM_PREFETCH_EN
      do_fetch(4, model_mem[4], LAT, 0, 0, 0);
      repeat (6) @(negedge clock);
      do_fetch(5, model_mem[5], 1, 0, 0, 0);
      repeat (6) @(negedge clock);
      do_fetch(9, model_mem[9], LAT, 0, 0, 0);
      do_fetch(4, model_mem[4], LAT, 0, 0, 0);
      repeat (6) @(negedge clock);
      load_word(30, 32'h0BAD_F00D);
      do_fetch(5, model_mem[5], LAT, 0, 0, 0);
`endif

      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
